// File: rtl/pkt_link_pkg.sv
// Shared definitions for the 8-bit byte-stream packet link (serializer and deserializer).
// Framing bytes, FSM state encoding, error codes and the checksum fold.
package pkt_link_pkg;

  localparam logic [7:0] HEADER_DEF  = 8'hAA;
  localparam logic [7:0] TRAILER_DEF = 8'h55;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    TRAIL = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  // Running packet checksum is a plain XOR of the payload bytes.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/deserializer_sat_counter.sv
// Saturating up-counter used for the good/bad packet statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register; increments stop once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/deserializer.sv
// Receive side of the packet link: delimits frames, streams payload with one cycle
// of latency, verifies length/checksum/trailer and keeps good/bad packet counts.
module deserializer
  import pkt_link_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter logic [7:0] TRAILER     = TRAILER_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         GAP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        sof,
  output logic        eof,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam int         GW        = $clog2(GAP_TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  state_e        r_state, w_state_nxt;
  logic [7:0]    r_rem, w_rem_nxt;
  logic [7:0]    r_xor, w_xor_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic          r_first, w_first_nxt;
  logic          w_fwd, w_sof, w_eof, w_ok, w_err;
  logic [1:0]    w_code;

  // Next-state and per-byte decisions; idle cycles only advance the gap counter.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_xor_nxt   = r_xor;
    w_gap_nxt   = r_gap;
    w_first_nxt = r_first;
    w_fwd       = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_code      = ERR_NONE;
    if (din_valid) begin
      w_gap_nxt = {GW{1'b0}};
      case (r_state)
        IDLE: begin
          if (din == HEADER) w_state_nxt = LEN;
          else               w_state_nxt = IDLE;
        end
        LEN: begin
          w_xor_nxt = 8'h00;
          if (din > MAX_LEN_B) begin
            w_err       = 1'b1;
            w_code      = ERR_LEN;
            w_state_nxt = IDLE;
          end else if (din == 8'd0) begin
            w_state_nxt = CSUM;
          end else begin
            w_rem_nxt   = din;
            w_first_nxt = 1'b1;
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          w_fwd       = 1'b1;
          w_sof       = r_first;
          w_eof       = (r_rem == 8'd1);
          w_first_nxt = 1'b0;
          w_xor_nxt   = csum_fold(r_xor, din);
          w_rem_nxt   = r_rem - 8'd1;
          if (r_rem == 8'd1) w_state_nxt = CSUM;
          else               w_state_nxt = DATA;
        end
        CSUM: begin
          if (din != r_xor) begin
            w_err       = 1'b1;
            w_code      = ERR_CSUM;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = TRAIL;
          end
        end
        TRAIL: begin
          w_state_nxt = IDLE;
          if (din == TRAILER) begin
            w_ok = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_FRAME;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      // A stalled link inside a frame is treated as a framing failure.
      if (r_gap == GAP_LAST) begin
        w_err       = 1'b1;
        w_code      = ERR_FRAME;
        w_gap_nxt   = {GW{1'b0}};
        w_state_nxt = IDLE;
      end else begin
        w_gap_nxt = r_gap + {{(GW-1){1'b0}}, 1'b1};
      end
    end else begin
      w_gap_nxt = {GW{1'b0}};
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rem      <= 8'd0;
      r_xor      <= 8'd0;
      r_gap      <= {GW{1'b0}};
      r_first    <= 1'b0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_xor      <= w_xor_nxt;
      r_gap      <= w_gap_nxt;
      r_first    <= w_first_nxt;
      dout_valid <= w_fwd;
      sof        <= w_sof;
      eof        <= w_eof;
      pkt_ok     <= w_ok;
      pkt_err    <= w_err;
      if (w_fwd) dout <= din;
      if (w_err) err_code <= w_code;
    end
  end

  sat_counter #(.W(16)) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ok),
    .o_cnt (ok_cnt)
  );

  sat_counter #(.W(16)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err),
    .o_cnt (err_cnt)
  );

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive side of the 8-bit byte-stream packet link; consumes the byte stream produced by the serializer.
- Delimits packets, strips framing, and forwards payload samples one per cycle.
- Checks length, checksum and trailer; reports per-packet status and running good/bad packet counts.
- Sits at the far end of the link, feeding downstream sample consumers.

Parameters:
- HEADER, 8'hAA, start-of-packet byte.
- TRAILER, 8'h55, end-of-packet byte.
- MAX_LEN, 16, largest legal payload length in samples (1..255).
- GAP_TIMEOUT, 8, consecutive din_valid-low cycles allowed inside a packet before abort (>=1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  incoming byte.
- din_valid  in  1  din carries a byte this cycle.
- dout  out  8  payload sample.
- dout_valid  out  1  dout is valid this cycle.
- sof  out  1  pulse with the first payload sample.
- eof  out  1  pulse with the last payload sample.
- pkt_ok  out  1  one-cycle pulse when a packet completes cleanly.
- pkt_err  out  1  one-cycle pulse when a packet is aborted.
- err_code  out  2  cause of the error; 1=bad length, 2=checksum, 3=trailer/timeout. Held until the next pkt_err.
- ok_cnt  out  16  count of good packets; saturates at 16'hFFFF.
- err_cnt  out  16  count of aborted packets; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FSM = IDLE. All outputs = 0, including counters and err_code.
- Packet format, in order: HEADER, LEN, LEN payload bytes, CSUM, TRAILER.
  - CSUM = XOR of the payload bytes.
  - LEN=0 is legal: no payload, CSUM must be 8'h00.
- Byte acceptance: a byte is consumed only on a cycle with din_valid=1. Cycles with din_valid=0 hold FSM state.
- FSM states and transitions:
  - IDLE: hunt for the header. din==HEADER -> LEN; any other byte is dropped silently (no error).
  - LEN: LEN>MAX_LEN -> error code 1, go to IDLE. LEN==0 -> CSUM. Otherwise load the remaining-count register -> DATA.
  - DATA: forward each byte and fold it into the running XOR. Decrement the remaining count; when the last byte is taken -> CSUM.
  - CSUM: byte != running XOR -> error code 2, go to IDLE. Otherwise -> TRAIL.
  - TRAIL: byte==TRAILER -> pkt_ok, go to IDLE. Otherwise -> error code 3, go to IDLE.
- Payload latency: exactly 1 cycle, registered. A byte accepted in DATA at cycle t appears as dout/dout_valid=1 at cycle t+1.
  - sof is asserted with the first payload sample; eof with the last.
  - LEN=1: sof and eof are high together.
  - dout holds its last value when dout_valid=0.
- Payload is streamed before verification. Downstream discards the in-flight packet on pkt_err.
- pkt_ok and pkt_err fire 1 cycle after the deciding byte; they are never high together.
- Gap timeout:
  - In LEN, DATA, CSUM and TRAIL, a gap counter increments on every din_valid=0 cycle and clears on every valid byte.
  - Reaching GAP_TIMEOUT -> pkt_err with code 3, go to IDLE. No sof/eof is emitted for the remainder of that packet.
  - The gap counter is inactive in IDLE.
- Error recovery: after any error the FSM is in IDLE. A HEADER byte on the very next valid cycle starts a new packet; no dead cycle.
- A HEADER value appearing inside the payload is treated as data; there is no resynchronisation mid-packet.
- Counters: ok_cnt increments on pkt_ok, err_cnt on pkt_err. Both saturate, never wrap.
- Reset mid-packet: everything returns to the reset state immediately. No pulse is emitted for the partial packet.
- Width rules: the remaining-count register is 8 bits. The gap counter is $clog2(GAP_TIMEOUT+1) bits.

Decomposition:
- Shared package pkt_link_pkg, used by both serializer and deserializer:
  - HEADER and TRAILER default values.
  - State enum: IDLE, LEN, DATA, CSUM, TRAIL.
  - Error-code constants: ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_FRAME=3.
- Optional sub-module sat_counter (16-bit saturating increment), instantiated twice for ok_cnt and err_cnt.
- Everything else stays in one module.

Test Plan:
- Back-to-back packet: AA 04 11 22 33 44 44 55 with din_valid continuous -> dout 11,22,33,44 on 4 consecutive cycles, starting 1 cycle after the 11 is accepted. sof with 11, eof with 44. pkt_ok 1 cycle after 55; ok_cnt=1.
- Noise and empty packet: 00 FF AA 00 00 55 -> the leading 00 FF are ignored. No dout_valid, pkt_ok pulses, ok_cnt=1, err_cnt=0.
- Bad checksum and recovery: AA 02 01 02 00 55 then AA 01 7E 7E 55 -> first packet pkt_err with err_code=2. Second packet yields dout=7E with sof=eof=1, then pkt_ok. ok_cnt=1, err_cnt=1.
- Bad length and bad trailer: AA 11 (17 > MAX_LEN) -> pkt_err code 1, no dout_valid. Then AA 01 05 05 56 -> dout=05 streamed, then pkt_err code 3.
- Gaps and timeout:
  - Insert 7 idle cycles between payload bytes -> packet still completes with pkt_ok.
  - Insert 8 idle cycles after the LEN byte -> pkt_err code 3 on the 8th idle cycle.
- Reset mid-packet and saturation:
  - Drop rst_n during DATA -> outputs 0 immediately. A following clean packet completes normally.
  - Force ok_cnt to FFFF and send a good packet -> ok_cnt stays FFFF.
